gray_tracker: RTL and testbench

Receive-side companion to the team's 3-bit Gray counter. It samples a Gray-coded count word qualified by a valid strobe and converts it to binary. It checks that every accepted sample either holds or advances by exactly one step. It counts wrap-arounds and flags sequence violations. It sits downstream of any Gray-coded counter or pointer and feeds binary position and status to consumers.

---
 rtl/gray_tracker.sv | 106 ++++++++++
 tb/tb_gray_tracker.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/gray_tracker.sv
// Tracks a Gray-coded counter: decodes to binary, checks hold/+1 steps, counts wraps, flags errors.
// Latency: a sample accepted at edge N shows on every output after edge N (1 cycle, all registered).
// Backpressure: none; every Valid-qualified sample is consumed on the edge it is presented.
module gray_tracker #(
   parameter int W  = 3,
   parameter int CW = 4
) (
   input  logic          Clk,
   input  logic          Reset,
   input  logic          Valid,
   input  logic [W-1:0]  GrayIn,
   output logic [W-1:0]  Binary,
   output logic          Step,
   output logic [CW-1:0] Wraps,
   output logic          Overflow,
   output logic          Locked,
   output logic          Error
);

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      LOCKED   = 2'd1,
      FAULT    = 2'd2
   } state_t;

   localparam logic [CW-1:0] WRAP_MAX = {CW{1'b1}};
   localparam logic [W-1:0]  BIN_MAX  = {W{1'b1}};
   localparam logic [W-1:0]  BIN_ONE  = W'(1);

   state_t         state;
   logic [W-1:0]   bin_new;
   logic [W-1:0]   delta;
   logic           is_wrap;

   // Gray-to-binary decode: each binary bit is the XOR of all Gray bits at or above it.
   always_comb begin
      bin_new = '0;
      bin_new[W-1] = GrayIn[W-1];
      for (int i = W-2; i >= 0; i--) begin
         bin_new[i] = bin_new[i+1] ^ GrayIn[i];
      end
   end

   // Modular distance from the held position; a legal sample is 0 (hold) or 1 (advance).
   always_comb begin
      delta   = bin_new - Binary;
      is_wrap = (Binary == BIN_MAX) && (bin_new == '0);
   end

   // Tracking state machine; Step is a pulse so it defaults low every cycle.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= UNLOCKED;
         Binary   <= '0;
         Step     <= 1'b0;
         Wraps    <= '0;
         Overflow <= 1'b0;
         Locked   <= 1'b0;
         Error    <= 1'b0;
      end else begin
         Step <= 1'b0;
         if (Valid) begin
            case (state)
               UNLOCKED: begin
                  // First sample is taken as the reference without any delta check.
                  Binary <= bin_new;
                  Locked <= 1'b1;
                  state  <= LOCKED;
               end
               LOCKED: begin
                  if (delta == '0) begin
                     // Counter held still; nothing to update.
                  end else if (delta == BIN_ONE) begin
                     Binary <= bin_new;
                     Step   <= 1'b1;
                     if (is_wrap) begin
                        Overflow <= 1'b1;
                        if (Wraps != WRAP_MAX) begin
                           Wraps <= Wraps + CW'(1);
                        end
                     end
                  end else begin
                     // Skips and backward moves both land here; position is frozen.
                     Error  <= 1'b1;
                     Locked <= 1'b0;
                     state  <= FAULT;
                  end
               end
               FAULT: begin
                  // Resynchronise only on a zero code so the restart point is unambiguous.
                  if (bin_new == '0) begin
                     Binary <= '0;
                     Locked <= 1'b1;
                     state  <= LOCKED;
                  end
               end
               default: begin
                  state  <= UNLOCKED;
                  Locked <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gray_tracker.sv
module tb_gray_tracker;

   typedef struct packed {
      logic [2:0] bin;
      logic       step;
      logic [3:0] wraps;
      logic       ovf;
      logic       lck;
      logic       err;
      logic [1:0] wraps2;
   } exp_t;

   logic       Clk;
   logic       Reset;
   logic       Valid;
   logic [2:0] GrayIn;

   logic [2:0] Binary,  Binary2;
   logic       Step,    Step2;
   logic [3:0] Wraps;
   logic [1:0] Wraps2;
   logic       Overflow, Overflow2;
   logic       Locked,  Locked2;
   logic       Error,   Error2;

   int errors = 0;
   int checks = 0;
   int step_no = 0;
   exp_t sb[$];
   logic [2:0] gtab [8];

   gray_tracker #(.W(3), .CW(4)) dut (
      .Clk(Clk), .Reset(Reset), .Valid(Valid), .GrayIn(GrayIn),
      .Binary(Binary), .Step(Step), .Wraps(Wraps), .Overflow(Overflow),
      .Locked(Locked), .Error(Error)
   );

   gray_tracker #(.W(3), .CW(2)) dut_cw2 (
      .Clk(Clk), .Reset(Reset), .Valid(Valid), .GrayIn(GrayIn),
      .Binary(Binary2), .Step(Step2), .Wraps(Wraps2), .Overflow(Overflow2),
      .Locked(Locked2), .Error(Error2)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   function automatic exp_t mk(input logic [2:0] bin, input logic step, input logic [3:0] wraps,
                               input logic ovf, input logic lck, input logic err,
                               input logic [1:0] wraps2);
      exp_t e;
      e.bin = bin; e.step = step; e.wraps = wraps; e.ovf = ovf;
      e.lck = lck; e.err = err; e.wraps2 = wraps2;
      return e;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL step %0d %s: observed=%0h expected=%0h", step_no, tag, obs, exp);
         $error("check %s at step %0d differs", tag, step_no);
      end
   endtask

   // Pop the expectation pushed when this cycle's stimulus was driven and compare.
   task automatic compare();
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL step %0d scoreboard: observed=empty expected=entry", step_no);
         return;
      end
      e = sb.pop_front();
      check("Binary",    8'(Binary),    8'(e.bin));
      check("Step",      8'(Step),      8'(e.step));
      check("Wraps",     8'(Wraps),     8'(e.wraps));
      check("Overflow",  8'(Overflow),  8'(e.ovf));
      check("Locked",    8'(Locked),    8'(e.lck));
      check("Error",     8'(Error),     8'(e.err));
      check("Wraps_cw2", 8'(Wraps2),    8'(e.wraps2));
      check("Binary_cw2", 8'(Binary2),  8'(e.bin));
      check("Overflow_cw2", 8'(Overflow2), 8'(e.ovf));
   endtask

   task automatic apply(input logic r, input logic v, input logic [2:0] g, input exp_t e);
      Reset  = r;
      Valid  = v;
      GrayIn = g;
      sb.push_back(e);
      @(posedge Clk);
      #1;
      step_no++;
      compare();
   endtask

   initial begin
      gtab[0] = 3'b000; gtab[1] = 3'b001; gtab[2] = 3'b011; gtab[3] = 3'b010;
      gtab[4] = 3'b110; gtab[5] = 3'b111; gtab[6] = 3'b101; gtab[7] = 3'b100;
      Reset = 1'b1; Valid = 1'b0; GrayIn = 3'b000;

      // Reset state
      apply(1, 0, 3'b000, mk(0, 0, 0, 0, 0, 0, 0));

      // Full count 0..7: first sample locks without Step, the rest step by one
      apply(0, 1, gtab[0], mk(0, 0, 0, 0, 1, 0, 0));
      for (int k = 1; k < 8; k++)
         apply(0, 1, gtab[k], mk(3'(k), 1, 0, 0, 1, 0, 0));

      // Wrap 7->0, then hold on 0, then Valid low with toggling input
      apply(0, 1, 3'b000, mk(0, 1, 1, 1, 1, 0, 1));
      for (int k = 0; k < 3; k++)
         apply(0, 1, 3'b000, mk(0, 0, 1, 1, 1, 0, 1));
      apply(0, 0, 3'b101, mk(0, 0, 1, 1, 1, 0, 1));
      apply(0, 0, 3'b011, mk(0, 0, 1, 1, 1, 0, 1));

      // Skip forward is an error; FAULT ignores nonzero codes and relocks on zero
      apply(1, 0, 3'b000, mk(0, 0, 0, 0, 0, 0, 0));
      apply(0, 1, 3'b001, mk(1, 0, 0, 0, 1, 0, 0));
      apply(0, 1, 3'b010, mk(1, 0, 0, 0, 0, 1, 0));
      apply(0, 1, 3'b011, mk(1, 0, 0, 0, 0, 1, 0));
      apply(0, 1, 3'b000, mk(0, 0, 0, 0, 1, 1, 0));
      apply(0, 1, 3'b001, mk(1, 1, 0, 0, 1, 1, 0));

      // Backward step is an error
      apply(1, 0, 3'b000, mk(0, 0, 0, 0, 0, 0, 0));
      apply(0, 1, 3'b011, mk(2, 0, 0, 0, 1, 0, 0));
      apply(0, 1, 3'b001, mk(2, 0, 0, 0, 0, 1, 0));
      apply(0, 1, 3'b101, mk(2, 0, 0, 0, 0, 1, 0));

      // Five full cycles: 4-bit counter reaches 5, 2-bit counter saturates at 3
      apply(1, 0, 3'b000, mk(0, 0, 0, 0, 0, 0, 0));
      apply(0, 1, 3'b000, mk(0, 0, 0, 0, 1, 0, 0));
      for (int c = 1; c <= 5; c++) begin
         for (int k = 1; k < 8; k++)
            apply(0, 1, gtab[k], mk(3'(k), 1, 4'(c-1), (c > 1), 1, 0,
                                    (c-1 > 3) ? 2'd3 : 2'(c-1)));
         apply(0, 1, 3'b000, mk(0, 1, 4'(c), 1, 1, 0, (c > 3) ? 2'd3 : 2'(c)));
      end

      // Reset mid-stream wins over a simultaneous valid sample and drops history
      for (int k = 1; k <= 5; k++)
         apply(0, 1, gtab[k], mk(3'(k), 1, 5, 1, 1, 0, 3));
      apply(1, 1, 3'b100, mk(0, 0, 0, 0, 0, 0, 0));
      apply(0, 1, 3'b110, mk(4, 0, 0, 0, 1, 0, 0));
      apply(0, 1, 3'b111, mk(5, 1, 0, 0, 1, 0, 0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
